// File: rtl/nco_freq_meter.sv
// Zero-crossing frequency meter: counts hysteresis-qualified rising crossings
// over a window of 2^WIN_LOG2 accepted samples and reports an NCO-style phase increment.
module nco_freq_meter #(
    parameter int DW       = 10,
    parameter int PW       = 32,
    parameter int WIN_LOG2 = 12,
    parameter int HYST     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clken,
    input  logic                in_valid,
    input  logic [DW-1:0]       fsin_i,
    output logic [PW-1:0]       phi_est_o,
    output logic [WIN_LOG2:0]   crossings_o,
    output logic [WIN_LOG2:0]   span_o,
    output logic                no_signal_o,
    output logic                est_valid
);

    typedef enum logic [1:0] {ST_UNK = 2'd0, ST_LOW = 2'd1, ST_HIGH = 2'd2} hyst_t;

    // One extra bit so -HYST and -2^(DW-1) compare without wrap.
    localparam logic signed [DW:0]       HP       = (DW+1)'(HYST);
    localparam logic signed [DW:0]       HN       = -HP;
    localparam logic [WIN_LOG2-1:0]      IDX_LAST = '1;

    hyst_t                 r_state, w_state_nxt;
    logic [WIN_LOG2-1:0]   r_idx, r_first, r_last;
    logic [WIN_LOG2:0]     r_cnt;

    logic signed [DW:0]    w_s;
    logic                  w_acc, w_hi, w_lo, w_cross;
    logic [WIN_LOG2:0]     w_cnt_nxt, w_span;
    logic [WIN_LOG2-1:0]   w_first_nxt, w_last_nxt;
    logic [PW-1:0]         w_phi;

    assign w_s   = $signed({fsin_i[DW-1], fsin_i});
    assign w_acc = clken & in_valid;
    assign w_hi  = (w_s >= HP);
    assign w_lo  = (w_s <= HN);

    always_comb begin
        w_state_nxt = r_state;
        w_cross     = 1'b0;
        case (r_state)
            ST_UNK: begin
                if (w_lo)      w_state_nxt = ST_LOW;
                else if (w_hi) w_state_nxt = ST_HIGH;
            end
            ST_LOW: begin
                if (w_hi) begin
                    w_state_nxt = ST_HIGH;
                    w_cross     = 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_lo) w_state_nxt = ST_LOW;
            end
            default: w_state_nxt = ST_UNK;
        endcase
    end

    // Window tallies including the sample being accepted this cycle, so a
    // crossing on the last index lands in the report it completes.
    assign w_cnt_nxt   = r_cnt + (WIN_LOG2+1)'(w_cross);
    assign w_first_nxt = (w_cross && (r_cnt == '0)) ? r_idx : r_first;
    assign w_last_nxt  = w_cross ? r_idx : r_last;
    assign w_span      = (w_cnt_nxt >= (WIN_LOG2+1)'(2)) ? {1'b0, w_last_nxt - w_first_nxt} : '0;
    assign w_phi       = PW'(w_cnt_nxt) << (PW - WIN_LOG2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_UNK;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_first     <= '0;
            r_last      <= '0;
            phi_est_o   <= '0;
            crossings_o <= '0;
            span_o      <= '0;
            no_signal_o <= 1'b1;
            est_valid   <= 1'b0;
        end else begin
            est_valid <= 1'b0;
            if (w_acc) begin
                r_state <= w_state_nxt;
                if (r_idx == IDX_LAST) begin
                    phi_est_o   <= w_phi;
                    crossings_o <= w_cnt_nxt;
                    span_o      <= w_span;
                    no_signal_o <= (w_cnt_nxt == '0);
                    est_valid   <= 1'b1;
                    r_idx       <= '0;
                    r_cnt       <= '0;
                    r_first     <= '0;
                    r_last      <= '0;
                end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_cnt   <= w_cnt_nxt;
                    r_first <= w_first_nxt;
                    r_last  <= w_last_nxt;
                end
            end
        end
    end

endmodule
